// File: rtl/instruction_fetch_unit.sv
// Single-slot instruction fetch stage: pc register, IF/ID slot with valid/ready handshake and redirect.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic               out_fault,
  output logic [31:0]        fetch_count,
  output logic [1:0]         dbg_state
);

  // Handshake: the slot transfers on a cycle where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_instr/out_pc/out_fault hold steady.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        accept;
  logic        load;
  logic        misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      slot_pc_q <= 32'd0;
      count_q   <= 32'd0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      slot_pc_q <= slot_pc_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  // Redirect wins over everything and always leaves BOOT.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = misaligned ? ST_FAULT : ST_RUN;
    end else if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    accept    = valid_q && out_ready;
    load      = (state_q == ST_RUN) && (!valid_q || out_ready);
    pc_d      = pc_q;
    instr_d   = instr_q;
    slot_pc_d = slot_pc_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    count_d   = count_q + {31'd0, accept};
    if (redirect_valid) begin
      // A misaligned target becomes a fault slot; otherwise flush and refetch.
      pc_d    = misaligned ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
      valid_d = misaligned;
      fault_d = misaligned;
      if (misaligned) begin
        slot_pc_d = redirect_pc;
        instr_d   = NOP;
      end
    end else if (load) begin
      instr_d   = imem_rdata;
      slot_pc_d = pc_q;
      valid_d   = 1'b1;
      fault_d   = 1'b0;
      pc_d      = pc_q + 32'd4;
    end else if (accept) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end
  end

  always_comb begin
    imem_addr   = pc_q[IMEM_AW+1:2];
    out_valid   = valid_q;
    out_instr   = instr_q;
    out_pc      = slot_pc_q;
    out_fault   = fault_q;
    fetch_count = count_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized
// redirects/back-pressure compared every cycle against a transaction-level model.
module tb_instruction_fetch_unit;

  localparam int          AW   = 10;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          out_fault;
  logic [31:0]   fetch_count;
  logic [1:0]    dbg_state;

  logic [31:0] mem [1024];
  int checks = 0;
  int errors = 0;

  // Model of the fetch stage as seen from outside: next fetch address, one slot.
  logic [31:0] m_pc, m_instr, m_opc, m_count;
  logic        m_valid, m_fault, m_boot, m_halted;

  instruction_fetch_unit #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault), .fetch_count(fetch_count),
    .dbg_state(dbg_state)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_instr = NOP; m_opc = 32'd0; m_count = 32'd0;
    m_valid = 1'b0; m_fault = 1'b0; m_boot = 1'b1; m_halted = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    if (m_valid && rdy) m_count = m_count + 1;
    if (rv) begin
      m_boot = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) begin
        m_valid = 1'b1; m_fault = 1'b1; m_opc = rpc; m_instr = NOP;
        m_halted = 1'b1; m_pc = rpc;
      end else
`endif
      begin
        m_valid = 1'b0; m_fault = 1'b0; m_halted = 1'b0;
        m_pc = {rpc[31:2], 2'b00};
      end
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      if (m_valid && rdy) m_valid = 1'b0;
    end else if (!m_valid || rdy) begin
      m_instr = mem[m_pc[11:2]];
      m_opc = m_pc; m_valid = 1'b1; m_fault = 1'b0;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    chk("valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("count", fetch_count, m_count);
    chk("imem_addr", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
    if (m_valid) begin
      chk("out_pc", out_pc, m_opc);
      chk("out_instr", out_instr, m_instr);
      chk("out_fault", {31'd0, out_fault}, {31'd0, m_fault});
    end
  endtask

  // Drive one cycle's inputs, advance the model, then compare at the falling edge.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    model_step(rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0000_0013);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_fault", {31'd0, out_fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_imem_addr", {22'd0, imem_addr}, 32'd0);

    // Start-up: one BOOT cycle, then back-to-back fetches.
    rst_n = 1'b1;
    cycle(1'b0, 32'd0, 1'b1);
    chk("boot_bubble", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_instr", out_instr, mem[0]);
    cycle(1'b0, 32'd0, 1'b1);
    chk("second_pc", out_pc, 32'h4);
    chk("second_instr", out_instr, mem[1]);
    cycle(1'b0, 32'd0, 1'b1);
    chk("third_pc", out_pc, 32'h8);
    chk("third_instr", out_instr, mem[2]);

    // Stall three cycles on 0x8.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'd0, 1'b0);
      chk("stall_pc", out_pc, 32'h8);
      chk("stall_instr", out_instr, mem[2]);
      chk("stall_addr", {22'd0, imem_addr}, 32'd3);
      chk("stall_count", fetch_count, 32'd2);
    end
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("pre_redir_pc", out_pc, 32'h10);

    // Redirect in the same cycle 0x10 is accepted.
    cycle(1'b1, 32'h100, 1'b1);
    chk("redir_flush", {31'd0, out_valid}, 32'd0);
    chk("redir_count", fetch_count, 32'd5);
    cycle(1'b0, 32'd0, 1'b1);
    chk("redir_target", out_pc, 32'h100);
    chk("redir_valid", {31'd0, out_valid}, 32'd1);

    // imem address wraps past the top of the 1024-word memory.
    cycle(1'b1, 32'hFF8, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap_prev_pc", out_pc, 32'hFFC);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap_pc", out_pc, 32'h1000);
    chk("wrap_instr", out_instr, mem[0]);

    // Misaligned redirect.
    cycle(1'b1, 32'h102, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_fault", {31'd0, out_fault}, 32'd1);
    chk("mis_pc", out_pc, 32'h102);
    chk("mis_instr", out_instr, 32'h0000_0013);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    chk("mis_hold_pc", out_pc, 32'h102);
    cycle(1'b0, 32'd0, 1'b1);
    chk("mis_accepted", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("mis_no_fetch", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 32'h200, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("mis_resume", out_pc, 32'h200);
    chk("mis_resume_fault", {31'd0, out_fault}, 32'd0);
`else
    chk("mis_flush", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("mis_resume", out_pc, 32'h100);
    chk("mis_fault", {31'd0, out_fault}, 32'd0);
`endif

    // Asynchronous reset while a slot is stalled.
    cycle(1'b0, 32'd0, 1'b0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_count", fetch_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("restart_pc", out_pc, RPC);
    chk("restart_instr", out_instr, mem[0]);

    // Randomized back-pressure and redirects.
    for (int n = 0; n < 3000; n++) begin
      logic        rv, rdy;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: tgt = $urandom & 32'h0000_1FFC;
        1: tgt = 32'h0000_0FF0 + ($urandom_range(0, 3) * 4);
        2: tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
        default: tgt = ($urandom & 32'h0000_0FFC) | $urandom_range(0, 3);
      endcase
      cycle(rv, tgt, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; bits [1:0] SHALL be 0.
REQ-002 Parameter: IMEM_AW, 10, word-address width driven to instruction memory (1024 words).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_addr  out  IMEM_AW  word address to instruction memory, combinational = pc[IMEM_AW+1:2].
REQ-006 imem_rdata  in  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 redirect_valid  in  1  branch/jump/trap redirect request from execute.
REQ-008 redirect_pc  in  32  redirect target byte address.
REQ-009 out_valid  out  1  IF/ID slot holds a valid instruction.
REQ-010 out_ready  in  1  decode accepts the slot this cycle.
REQ-011 out_instr  out  32  fetched instruction word.
REQ-012 out_pc  out  32  byte address of out_instr.
REQ-013 out_fault  out  1  slot carries an instruction-address-misaligned fault (Configuration only).
REQ-014 fetch_count  out  32  count of instructions accepted by decode.

Function
REQ-015 Internal pc register SHALL hold the address of the next fetch; imem_addr SHALL be derived from pc every cycle, including while stalled.
REQ-016 State machine states: BOOT, RUN, FAULT; BOOT SHALL last exactly one cycle after reset release, then go to RUN.
REQ-017 In RUN, load condition = !out_valid || out_ready; when true and no redirect, slot SHALL capture {imem_rdata, pc}, out_valid<=1, pc<=pc+4.
REQ-018 When load condition false and no redirect, slot, out_valid and pc SHALL hold (stall); out_instr/out_pc SHALL be stable while out_valid && !out_ready.
REQ-019 redirect_valid SHALL have priority over load and stall: next cycle out_valid<=0 (flush), pc<=redirect_pc, state<=RUN; first redirected instruction is valid two cycles after the redirect edge (one-bubble penalty).
REQ-020 A redirect arriving in the same cycle as out_valid && out_ready SHALL still count the accepted instruction in fetch_count.
REQ-021 Redirects during BOOT SHALL be honoured and SHALL end BOOT.
REQ-022 pc arithmetic SHALL be modulo 2^32; imem_addr SHALL wrap with pc bits above IMEM_AW+1 ignored (0x0000_0FFC+4 fetches word 0).
REQ-023 fetch_count SHALL increment by 1 on each out_valid && out_ready cycle, wrapping from 0xFFFF_FFFF to 0.
REQ-024 Throughput SHALL be one instruction per cycle when out_ready is held high and no redirect occurs.

Reset
REQ-025 While rst_n=0: pc=RESET_PC, state=BOOT, out_valid=0, out_instr=32'h0000_0013, out_pc=0, out_fault=0, fetch_count=0.
REQ-026 Reset asserted mid-operation SHALL discard the slot immediately (asynchronously) with no further handshake.

Configuration
REQ-027 Macro FETCH_MISALIGN_TRAP_EN.
REQ-028 Defined: redirect with redirect_pc[1:0]!=0 SHALL next cycle set out_valid=1, out_fault=1, out_pc=redirect_pc, out_instr=32'h0000_0013, state=FAULT; FAULT SHALL stop fetching (pc holds) until the next redirect, and the fault slot SHALL obey out_ready like any other slot, clearing out_valid once accepted.
REQ-029 Undefined: redirect_pc[1:0] SHALL be forced to 0 when loaded into pc; out_fault tied 0; FAULT state unreachable.

Verification
REQ-030 Reset release, out_ready=1, RESET_PC=0 -> out_valid rises 2 cycles after release, out_pc 0,4,8 on consecutive cycles, out_instr = mem words 0,1,2.
REQ-031 out_ready=0 for 3 cycles with out_pc=0x8 -> out_pc/out_instr held at 0x8 all 3 cycles, imem_addr=3, fetch_count unchanged.
REQ-032 redirect_valid=1, redirect_pc=0x100 while out_pc=0x10 accepted -> next cycle out_valid=0, then out_pc=0x100; fetch_count includes 0x10.
REQ-033 pc reaches 0xFFC -> next slot out_pc=0x1000, out_instr = mem word 0.
REQ-034 FETCH_MISALIGN_TRAP_EN defined, redirect_pc=0x102 -> out_fault=1, out_pc=0x102, out_instr=0x00000013, no further fetch until redirect to 0x200 resumes at 0x200; undefined -> fetch resumes at 0x100.
REQ-035 rst_n pulsed low while out_valid=1, out_ready=0 -> out_valid=0 and fetch_count=0 immediately, restart at RESET_PC.
